enemy_hit_engine: RTL

//  Time-multiplexed bullet/enemy collision and health manager; successor to the single-cycle alive controller.

---
 rtl/enemy_hit_pkg.sv | 36 +++
 rtl/enemy_hit_engine_cmp.sv | 33 +++
 rtl/enemy_hit_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/enemy_hit_pkg.sv
// Shared types and helpers for the enemy hit engine: coordinate width, scan FSM
// states, default hitbox size and a lowest-set-bit finder.
package enemy_hit_pkg;

    localparam int COORD_W      = 10;
    localparam int DEF_HITBOX_W = 32;
    localparam int DEF_HITBOX_H = 32;
    localparam int MAX_BULLETS  = 32;
    localparam int BIDX_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              found;
        logic [BIDX_W-1:0] idx;
    } first_one_t;

    // Lowest set bit wins; scanning downward leaves the lowest index last.
    function automatic first_one_t first_one(input logic [MAX_BULLETS-1:0] mask);
        first_one_t r;
        r.found = 1'b0;
        r.idx   = {BIDX_W{1'b0}};
        for (int k = MAX_BULLETS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                r.found = 1'b1;
                r.idx   = BIDX_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/enemy_hit_engine_cmp.sv
// Point-in-box test for one bullet against the currently scanned enemy.
// Coordinates are widened by one bit so boxes near x/y=1023 do not wrap.
module hit_box_cmp
    import enemy_hit_pkg::*;
#(
    parameter int HITBOX_W = DEF_HITBOX_W,
    parameter int HITBOX_H = DEF_HITBOX_H
) (
    input  logic [COORD_W-1:0] box_x_i,
    input  logic [COORD_W-1:0] box_y_i,
    input  logic [COORD_W-1:0] pt_x_i,
    input  logic [COORD_W-1:0] pt_y_i,
    input  logic               en_i,
    output logic               hit_o
);

    localparam int CW = COORD_W + 1;

    logic [CW-1:0] box_x_s;
    logic [CW-1:0] box_y_s;
    logic [CW-1:0] pt_x_s;
    logic [CW-1:0] pt_y_s;

    assign box_x_s = {1'b0, box_x_i};
    assign box_y_s = {1'b0, box_y_i};
    assign pt_x_s  = {1'b0, pt_x_i};
    assign pt_y_s  = {1'b0, pt_y_i};

    assign hit_o = en_i
                 & (pt_x_s >= box_x_s) & (pt_x_s < box_x_s + CW'(HITBOX_W))
                 & (pt_y_s >= box_y_s) & (pt_y_s < box_y_s + CW'(HITBOX_H));

endmodule

// File: rtl/enemy_hit_engine.sv
// Frame-scanned bullet/enemy collision and health manager: one enemy per clk25
// cycle against all snapshotted bullets, with hit points, hurt timers and kills.
module enemy_hit_engine
    import enemy_hit_pkg::*;
#(
    parameter int ENEMY_COUNT  = 23,
    parameter int BULLET_COUNT = 8,
    parameter int HITBOX_W     = DEF_HITBOX_W,
    parameter int HITBOX_H     = DEF_HITBOX_H,
    parameter int HP_W         = 2,
    parameter int HURT_FRAMES  = 4
) (
    input  logic                                   clk25,
    input  logic                                   rst_n,
    input  logic                                   frame_start,
    input  logic [BULLET_COUNT-1:0][COORD_W-1:0]   bullet_x,
    input  logic [BULLET_COUNT-1:0][COORD_W-1:0]   bullet_y,
    input  logic [BULLET_COUNT-1:0]                bullet_active,
    input  logic [ENEMY_COUNT-1:0][COORD_W-1:0]    enemy_x,
    input  logic [ENEMY_COUNT-1:0][COORD_W-1:0]    enemy_y,
    input  logic [ENEMY_COUNT-1:0]                 revive_mask,
    input  logic [HP_W-1:0]                        revive_hp,
    output logic [ENEMY_COUNT-1:0]                 enemy_alive,
    output logic [ENEMY_COUNT-1:0]                 enemy_hurt,
    output logic [BULLET_COUNT-1:0]                bullet_hit,
    output logic                                   kill_valid,
    output logic [$clog2(ENEMY_COUNT)-1:0]         kill_idx,
    output logic                                   scan_busy,
    output logic                                   scan_done,
    output logic                                   scan_overrun
);

    localparam int IDX_W  = $clog2(ENEMY_COUNT);
    localparam int HURT_W = (HURT_FRAMES > 0) ? $clog2(HURT_FRAMES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENEMY_COUNT - 1);

    state_e                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [BULLET_COUNT-1:0][COORD_W-1:0]  bx_q, by_q;
    logic [BULLET_COUNT-1:0]               bact_q;
    logic [BULLET_COUNT-1:0]               consumed_q, consumed_d;
    logic [ENEMY_COUNT-1:0][HP_W-1:0]      hp_q, hp_d;
    logic [ENEMY_COUNT-1:0][HURT_W-1:0]    hurt_q, hurt_d;
    logic [ENEMY_COUNT-1:0]                alive_q, alive_d, hurt_flag_q, hurt_flag_d;
    logic [BULLET_COUNT-1:0]               bhit_q, bhit_d;
    logic                                  kill_valid_q, kill_valid_d;
    logic [IDX_W-1:0]                      kill_idx_q, kill_idx_d;
    logic                                  busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

    logic                    start_s, scan_s, dmg_s, hittable_s;
    logic [COORD_W-1:0]      cur_x_s, cur_y_s;
    logic [HP_W-1:0]         hp_cur_s, revive_val_s;
    logic [HURT_W-1:0]       hurt_cur_s;
    logic [BULLET_COUNT-1:0] hit_vec_s;
    first_one_t              pick_s;

    assign start_s      = (state_q == IDLE) & frame_start;
    assign scan_s       = (state_q == SCAN);
    assign cur_x_s      = enemy_x[idx_q];
    assign cur_y_s      = enemy_y[idx_q];
    assign hp_cur_s     = hp_q[idx_q];
    assign hurt_cur_s   = hurt_q[idx_q];
    assign revive_val_s = (revive_hp == {HP_W{1'b0}}) ? HP_W'(1) : revive_hp;
    assign hittable_s   = (hp_cur_s != {HP_W{1'b0}}) & (hurt_cur_s == {HURT_W{1'b0}});

    for (genvar j = 0; j < BULLET_COUNT; j++) begin : g_cmp
        hit_box_cmp #(
            .HITBOX_W (HITBOX_W),
            .HITBOX_H (HITBOX_H)
        ) u_cmp (
            .box_x_i (cur_x_s),
            .box_y_i (cur_y_s),
            .pt_x_i  (bx_q[j]),
            .pt_y_i  (by_q[j]),
            .en_i    (bact_q[j] & ~consumed_q[j]),
            .hit_o   (hit_vec_s[j])
        );
    end

    assign pick_s = first_one(MAX_BULLETS'(hit_vec_s));
    assign dmg_s  = scan_s & hittable_s & pick_s.found;

    // FSM state register
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = frame_start ? SCAN : IDLE;
            SCAN:    state_d = (idx_q == LAST_IDX) ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs (next values of the registered status pulses)
    always_comb begin
        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
        bhit_d = (state_d == DONE) ? consumed_d : {BULLET_COUNT{1'b0}};
        ovr_d  = frame_start & (state_q != IDLE);
    end

    // Damage, hurt timers, consumed mask and revive; revive overrides same-cycle damage
    always_comb begin
        hp_d         = hp_q;
        hurt_d       = hurt_q;
        consumed_d   = consumed_q;
        kill_valid_d = 1'b0;
        kill_idx_d   = kill_idx_q;
        idx_d        = (scan_s && (idx_q != LAST_IDX)) ? idx_q + IDX_W'(1) : {IDX_W{1'b0}};
        if (start_s) begin
            consumed_d = {BULLET_COUNT{1'b0}};
        end else if (scan_s) begin
            if (dmg_s) begin
                for (int j = 0; j < BULLET_COUNT; j++) begin
                    consumed_d[j] = consumed_q[j] | (pick_s.idx == BIDX_W'(j));
                end
                hp_d[idx_q] = hp_cur_s - HP_W'(1);
                if (hp_cur_s == HP_W'(1)) begin
                    kill_valid_d = 1'b1;
                    kill_idx_d   = idx_q;
                end else begin
                    hurt_d[idx_q] = HURT_W'(HURT_FRAMES);
                end
            end else if (hurt_cur_s != {HURT_W{1'b0}}) begin
                hurt_d[idx_q] = hurt_cur_s - HURT_W'(1);
            end else begin
                hurt_d[idx_q] = hurt_cur_s;
            end
        end else begin
            consumed_d = consumed_q;
        end
        for (int e = 0; e < ENEMY_COUNT; e++) begin
            hp_d[e]        = revive_mask[e] ? revive_val_s : hp_d[e];
            hurt_d[e]      = revive_mask[e] ? {HURT_W{1'b0}} : hurt_d[e];
            alive_d[e]     = (hp_d[e] != {HP_W{1'b0}});
            hurt_flag_d[e] = (hurt_d[e] != {HURT_W{1'b0}});
        end
        kill_valid_d = kill_valid_d & ~revive_mask[idx_q];
    end

    // Datapath and output registers
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= {IDX_W{1'b0}};
            bx_q         <= '0;
            by_q         <= '0;
            bact_q       <= {BULLET_COUNT{1'b0}};
            consumed_q   <= {BULLET_COUNT{1'b0}};
            hp_q         <= '0;
            hurt_q       <= '0;
            alive_q      <= {ENEMY_COUNT{1'b0}};
            hurt_flag_q  <= {ENEMY_COUNT{1'b0}};
            bhit_q       <= {BULLET_COUNT{1'b0}};
            kill_valid_q <= 1'b0;
            kill_idx_q   <= {IDX_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            if (start_s) begin
                bx_q   <= bullet_x;
                by_q   <= bullet_y;
                bact_q <= bullet_active;
            end else begin
                bact_q <= bact_q;
            end
            idx_q        <= idx_d;
            consumed_q   <= consumed_d;
            hp_q         <= hp_d;
            hurt_q       <= hurt_d;
            alive_q      <= alive_d;
            hurt_flag_q  <= hurt_flag_d;
            bhit_q       <= bhit_d;
            kill_valid_q <= kill_valid_d;
            kill_idx_q   <= kill_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
        end
    end

    assign enemy_alive  = alive_q;
    assign enemy_hurt   = hurt_flag_q;
    assign bullet_hit   = bhit_q;
    assign kill_valid   = kill_valid_q;
    assign kill_idx     = kill_idx_q;
    assign scan_busy    = busy_q;
    assign scan_done    = done_q;
    assign scan_overrun = ovr_q;

endmodule
